ir_tx_encoder: RTL and testbench

IR_TX_ENCODER -- requirements
Module: ir_tx_encoder

---
 rtl/ir_tx_encoder.sv | 160 ++++++++++++++++
 tb/tb_ir_tx_encoder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ir_tx_encoder.sv
// IR remote transmitter: sends a 3-bit button code as a low start pulse followed by three timed bit slots, then a high guard gap.
// Latency: irda_tx falls one clk after an accepted send; slot boundaries follow T_x ticks of DIV clk each.
// Backpressure: busy=1 for the whole frame and guard; send while busy is dropped; malformed key pulses err.
//
// Ports:
//   clk      system clock, rising edge
//   rst      synchronous active-high reset
//   send     frame request, sampled every clk
//   key[4:0] one-hot button {power, blue, yellow, green, red}
//   irda_tx  registered IR line, idle high
//   busy     frame or guard in progress
//   done     one-cycle pulse when the guard gap ends
//   err      one-cycle pulse when a request carries a zero or multi-hot key
module ir_tx_encoder #(
    parameter int DIV   = 1,
    parameter int T_B2  = 180,
    parameter int T_B1  = 220,
    parameter int T_B0  = 248,
    parameter int T_END = 270,
    parameter int GUARD = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [4:0] key,
    output logic       irda_tx,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam int T_LAST = T_END + GUARD;
    localparam int TW     = $clog2(T_LAST + 1);
    localparam int PW     = $clog2(DIV + 1);

    localparam logic [TW-1:0] B2_T   = TW'(T_B2);
    localparam logic [TW-1:0] B1_T   = TW'(T_B1);
    localparam logic [TW-1:0] B0_T   = TW'(T_B0);
    localparam logic [TW-1:0] END_T  = TW'(T_END);
    localparam logic [TW-1:0] LAST_T = TW'(T_LAST);
    localparam logic [PW-1:0] DIV_M1 = PW'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_BIT2  = 3'd2,
        S_BIT1  = 3'd3,
        S_BIT0  = 3'd4,
        S_GUARD = 3'd5
    } state_t;

    state_t        state, state_nx;
    logic [TW-1:0] t, t_nx;
    logic [PW-1:0] pre, pre_nx;
    logic [2:0]    code, code_nx;
    logic          irda_tx_nx, done_nx, err_nx;
    logic [2:0]    key_code;
    logic          key_ok;

    // Button to code map; anything not exactly one-hot is rejected.
    always_comb begin
        key_code = 3'b000;
        key_ok   = 1'b1;
        case (key)
            5'b00001: key_code = 3'b011; // red
            5'b00010: key_code = 3'b010; // green
            5'b00100: key_code = 3'b110; // yellow
            5'b01000: key_code = 3'b100; // blue
            5'b10000: key_code = 3'b001; // power
            default:  key_ok   = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            t       <= '0;
            pre     <= '0;
            code    <= 3'b000;
            irda_tx <= 1'b1;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state   <= state_nx;
            t       <= t_nx;
            pre     <= pre_nx;
            code    <= code_nx;
            irda_tx <= irda_tx_nx;
            done    <= done_nx;
            err     <= err_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        t_nx       = t;
        pre_nx     = pre;
        code_nx    = code;
        done_nx    = 1'b0;
        err_nx     = 1'b0;
        irda_tx_nx = 1'b1;

        case (state)
            S_IDLE: begin
                if (send) begin
                    if (key_ok) begin
                        state_nx = S_START;
                        t_nx     = '0;
                        pre_nx   = '0;
                        code_nx  = key_code;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            S_START, S_BIT2, S_BIT1, S_BIT0, S_GUARD: begin
                if (pre == DIV_M1) begin
                    pre_nx = '0;
                    t_nx   = t + TW'(1);
                end else begin
                    pre_nx = pre + PW'(1);
                end
                // The slot is a pure function of the upcoming tick count, so the
                // registered line changes on exactly the boundary cycle.
                if (t_nx < B2_T)
                    state_nx = S_START;
                else if (t_nx < B1_T)
                    state_nx = S_BIT2;
                else if (t_nx < B0_T)
                    state_nx = S_BIT1;
                else if (t_nx < END_T)
                    state_nx = S_BIT0;
                else if (t_nx < LAST_T)
                    state_nx = S_GUARD;
                else begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                    t_nx     = '0;
                    pre_nx   = '0;
                end
            end
            default: begin
                state_nx = S_IDLE;
                t_nx     = '0;
                pre_nx   = '0;
            end
        endcase

        case (state_nx)
            S_START: irda_tx_nx = 1'b0;
            S_BIT2:  irda_tx_nx = code_nx[2];
            S_BIT1:  irda_tx_nx = code_nx[1];
            S_BIT0:  irda_tx_nx = code_nx[0];
            default: irda_tx_nx = 1'b1;
        endcase
    end

    assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ir_tx_encoder.sv
// Directed bench for ir_tx_encoder: DIV=1 instance checked cycle by cycle, DIV=4 instance checked by loopback decode.
// Latency: frames observed from the accept cycle through one cycle past done.
// Backpressure: exercises send while busy, malformed keys, reset abort and same-cycle re-accept.
module tb_ir_tx_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       send, send4;
    logic [4:0] key, key4;
    logic       tx, busy, done, err;
    logic       tx4, busy4, done4, err4;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    ir_tx_encoder dut (
        .clk(clk), .rst(rst), .send(send), .key(key),
        .irda_tx(tx), .busy(busy), .done(done), .err(err)
    );

    ir_tx_encoder #(.DIV(4)) u4 (
        .clk(clk), .rst(rst), .send(send4), .key(key4),
        .irda_tx(tx4), .busy(busy4), .done(done4), .err(err4)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level k cycles after the accept cycle with default timing.
    function automatic logic exp_tx(input int k, input logic [2:0] c);
        if (k <= 180)      return 1'b0;
        else if (k <= 220) return c[2];
        else if (k <= 248) return c[1];
        else if (k <= 270) return c[0];
        else               return 1'b1;
    endfunction

    // Issue a request now (sampled at the next rising edge) and check every cycle
    // 1..ncyc after it. Optionally inject a second send at cycle ovl_at or a reset at rst_at.
    task automatic do_frame(input logic [4:0] k, input logic [2:0] c, input int ovl_at,
                            input logic [4:0] ovl_key, input int rst_at, input int ncyc);
        logic ab, etx, ebusy, edone;
        send = 1'b1;
        key  = k;
        @(posedge clk);
        #1;
        send = 1'b0;
        key  = 5'b00000;
        for (int kk = 1; kk <= ncyc; kk++) begin
            @(negedge clk);
            ab    = (rst_at > 0) && (kk > rst_at);
            etx   = ab ? 1'b1 : exp_tx(kk, c);
            ebusy = ab ? 1'b0 : (kk <= 334);
            edone = !ab && (kk == 335);
            chk($sformatf("tx@%0d", kk),   {7'b0, tx},   {7'b0, etx});
            chk($sformatf("busy@%0d", kk), {7'b0, busy}, {7'b0, ebusy});
            chk($sformatf("done@%0d", kk), {7'b0, done}, {7'b0, edone});
            chk($sformatf("err@%0d", kk),  {7'b0, err},  8'h00);
            if (kk == ovl_at) begin
                send = 1'b1;
                key  = ovl_key;
            end
            if (kk == ovl_at + 1) begin
                send = 1'b0;
                key  = 5'b00000;
            end
            if (kk == rst_at) rst = 1'b1;
            if (kk == rst_at + 1) rst = 1'b0;
        end
    endtask

    task automatic bad_key(input logic [4:0] k);
        @(posedge clk);
        #1;
        send = 1'b1;
        key  = k;
        @(posedge clk);
        #1;
        send = 1'b0;
        key  = 5'b00000;
        @(negedge clk);
        chk("err_pulse", {7'b0, err},  8'h01);
        chk("err_busy",  {7'b0, busy}, 8'h00);
        chk("err_tx",    {7'b0, tx},   8'h01);
        @(negedge clk);
        chk("err_clear", {7'b0, err},  8'h00);
        chk("err_tx2",   {7'b0, tx},   8'h01);
    endtask

    // DIV=4: sample at 4x the 195/237/258 points after the falling edge.
    task automatic loop4(input logic [4:0] k, input logic [2:0] c);
        logic [2:0] got;
        @(negedge clk);
        send4 = 1'b1;
        key4  = k;
        @(posedge clk);
        #1;
        send4 = 1'b0;
        key4  = 5'b00000;
        @(negedge clk);
        chk("fe4", {7'b0, tx4}, 8'h00);
        repeat (780) @(negedge clk);
        got[2] = tx4;
        repeat (948 - 780) @(negedge clk);
        got[1] = tx4;
        repeat (1032 - 948) @(negedge clk);
        got[0] = tx4;
        chk("loop4_code", {5'b0, got}, {5'b0, c});
        for (int i = 0; i < 1400 && done4 !== 1'b1; i++) @(negedge clk);
        chk("done4", {7'b0, done4}, 8'h01);
        chk("busy4", {7'b0, busy4}, 8'h00);
    endtask

    initial begin
        rst   = 1'b1;
        send  = 1'b0;
        key   = 5'b00000;
        send4 = 1'b0;
        key4  = 5'b00000;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tx",    {7'b0, tx},    8'h01);
        chk("rst_busy",  {7'b0, busy},  8'h00);
        chk("rst_done",  {7'b0, done},  8'h00);
        chk("rst_err",   {7'b0, err},   8'h00);
        chk("rst_tx4",   {7'b0, tx4},   8'h01);
        chk("rst_busy4", {7'b0, busy4}, 8'h00);

        // Malformed keys
        bad_key(5'b00000);
        bad_key(5'b00110);
        bad_key(5'b11111);

        // All five codes, plus an ignored overlap send, a reset abort and a back-to-back start
        do_frame(5'b00001, 3'b011, 0,   5'b00000, 0,   336); // red
        do_frame(5'b00010, 3'b010, 0,   5'b00000, 0,   336); // green
        do_frame(5'b00100, 3'b110, 100, 5'b01000, 0,   336); // yellow, blue send ignored
        do_frame(5'b01000, 3'b100, 0,   5'b00000, 200, 336); // blue, aborted
        do_frame(5'b10000, 3'b001, 0,   5'b00000, 0,   335); // power, stop on done cycle
        do_frame(5'b00001, 3'b011, 0,   5'b00000, 0,   336); // red accepted alongside done

        // Reset wins over a valid send in the same cycle
        @(negedge clk);
        rst  = 1'b1;
        send = 1'b1;
        key  = 5'b00010;
        @(negedge clk);
        rst  = 1'b0;
        send = 1'b0;
        key  = 5'b00000;
        chk("rstpri_busy", {7'b0, busy}, 8'h00);
        chk("rstpri_tx",   {7'b0, tx},   8'h01);
        chk("rstpri_err",  {7'b0, err},  8'h00);
        @(negedge clk);
        chk("rstpri_busy2", {7'b0, busy}, 8'h00);
        chk("rstpri_tx2",   {7'b0, tx},   8'h01);

        // Slow build loopback
        loop4(5'b00001, 3'b011);
        loop4(5'b00010, 3'b010);
        loop4(5'b00100, 3'b110);
        loop4(5'b01000, 3'b100);
        loop4(5'b10000, 3'b001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
